// File: rtl/rvx_async_channel_arbiter.sv
// rtl/rvx_async_channel_arbiter.sv - round-robin packet arbiter in front of an async FIFO write port
// A grant is held for a whole packet; each beat is tagged with its source id in a one-entry output register.
module rvx_async_channel_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rstp,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [ID_WIDTH-1:0]          grant_id
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                state;
  state_t                next_state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   pick_id;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  pick_found;
  logic [ID_WIDTH:0]     cand;
  logic                  accept;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat_last;

  // Search starts at rr_ptr; one extra bit lets the sum wrap for non-power-of-two counts.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (ID_WIDTH+1)'(rr_ptr) + (ID_WIDTH+1)'(k);
      if (cand >= (ID_WIDTH+1)'(NUM_REQ)) begin
        cand = cand - (ID_WIDTH+1)'(NUM_REQ);
      end
      if (!pick_found && req_valid[cand[ID_WIDTH-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[ID_WIDTH-1:0];
      end
    end
  end

  assign next_ptr = (pick_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : pick_id + ID_WIDTH'(1);

  always_comb begin
    req_ready = '0;
    if (state == GRANT && (!out_valid || out_ready)) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign beat_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign beat_last = req_last[grant_id];
  assign accept    = req_valid[grant_id] & req_ready[grant_id];
  assign busy      = (state == GRANT);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = GRANT;
      GRANT:   if (accept && beat_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (state == IDLE && pick_found) begin
      grant_id <= pick_id;
      rr_ptr   <= next_ptr;
    end
  end

  // A new beat takes precedence over draining, so back-to-back beats keep out_valid high.
  always_ff @(posedge clk) begin
    if (rstp) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= {grant_id, beat_data};
      out_last  <= beat_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rvx_async_channel_arbiter.sv
// tb/tb_rvx_async_channel_arbiter.sv - self-checking bench for rvx_async_channel_arbiter
// Sources replay per-requester beat queues; a packet-level round-robin model predicts the output order.
module tb_rvx_async_channel_arbiter;

  logic        clk = 1'b0;
  logic        rstp;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [5:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;
  logic [1:0]  grant_id;

  rvx_async_channel_arbiter dut (
    .clk(clk), .rstp(rstp), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] src_q[4][$];
  logic [3:0] mid_pkt;
  logic [6:0] out_log[$];
  int         gap_pct    = 0;
  int         stall_pct  = 0;
  bit         rand_ready = 1'b0;

  // Drive one cycle of sources, record handshakes, then advance to just after the next edge.
  task automatic cycle();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]       = mid_pkt[i] ? ($urandom_range(0, 99) >= gap_pct) : 1'b1;
        req_data[i*4 +: 4] = src_q[i][0][3:0];
        req_last[i]        = src_q[i][0][4];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*4 +: 4] = 4'h0;
        req_last[i]        = 1'b0;
      end
    end
    if (rand_ready) out_ready = ($urandom_range(0, 99) >= stall_pct);
    #1;
    n_checks++;
    if (req_ready !== 4'b0 && (!busy || req_ready !== (4'b0001 << grant_id))) begin
      n_fail++;
      $display("FAIL ready_onehot: req_ready=%b busy=%b grant_id=%0d", req_ready, busy, grant_id);
    end
    if (out_valid && out_ready) out_log.push_back({out_last, out_data});
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        mid_pkt[i] = !src_q[i][0][4];
        void'(src_q[i].pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 4; i++) src_q[i].delete();
    mid_pkt = 4'b0;
    out_log.delete();
  endtask

  task automatic do_reset();
    rstp = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rstp = 1'b0;
    clear_sources();
  endtask

  task automatic test_reset();
    rstp = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    out_ready = 1'b1;
    clear_sources();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_data, out_last, req_ready, busy, grant_id} !== 15'b0) begin
        n_fail++;
        $display("FAIL reset_held[%0d]: ov=%b od=%h ol=%b rr=%b busy=%b gid=%0d want all 0",
                 k, out_valid, out_data, out_last, req_ready, busy, grant_id);
      end
    end
    rstp = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++;
      if ({out_valid, out_data, out_last, req_ready, busy, grant_id} !== 15'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: ov=%b od=%h ol=%b rr=%b busy=%b gid=%0d want all 0",
                 k, out_valid, out_data, out_last, req_ready, busy, grant_id);
      end
    end
  endtask

  task automatic test_single_packet();
    bit         eb[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit         ev[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [6:0] eo[5] = '{7'h00, 7'h21, 7'h22, 7'h63, 7'h00};
    clear_sources();
    rand_ready = 1'b0; out_ready = 1'b1; gap_pct = 0;
    src_q[2].push_back(5'h01);
    src_q[2].push_back(5'h02);
    src_q[2].push_back(5'h13);
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++;
      if (busy !== eb[k] || out_valid !== ev[k]) begin
        n_fail++;
        $display("FAIL single_ctrl[%0d]: busy=%b out_valid=%b want %b %b", k, busy, out_valid, eb[k], ev[k]);
      end
      if (ev[k]) begin
        n_checks++;
        if ({out_last, out_data} !== eo[k]) begin
          n_fail++;
          $display("FAIL single_beat[%0d]: got %h want %h", k, {out_last, out_data}, eo[k]);
        end
      end
      if (k == 0) begin
        n_checks++;
        if (grant_id !== 2'd2) begin
          n_fail++;
          $display("FAIL single_grant: grant_id=%0d want 2", grant_id);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] exp_log[$];
    logic [3:0] d;
    do_reset();
    rand_ready = 1'b0; out_ready = 1'b1; gap_pct = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        d = 4'($urandom);
        src_q[i].push_back({1'b1, d});
        exp_log.push_back({1'b1, 2'(i), d});
      end
    end
    for (int k = 0; k < 16; k++) begin
      cycle();
      n_checks++;
      if (busy !== (k % 2 == 0)) begin
        n_fail++;
        $display("FAIL rr_gap[%0d]: busy=%b want %b", k, busy, (k % 2 == 0));
      end
      if (k % 2 == 0) begin
        n_checks++;
        if (grant_id !== 2'((k / 2) % 4)) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: grant_id=%0d want %0d", k, grant_id, (k / 2) % 4);
        end
      end
    end
    cycle();
    cycle();
    n_checks++;
    if (out_log.size() != exp_log.size()) begin
      n_fail++;
      $display("FAIL rr_count: got %0d beats want %0d", out_log.size(), exp_log.size());
    end else begin
      foreach (exp_log[j]) begin
        n_checks++;
        if (out_log[j] !== exp_log[j]) begin
          n_fail++;
          $display("FAIL rr_beat[%0d]: got %h want %h", j, out_log[j], exp_log[j]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] a, b;
    clear_sources();
    rand_ready = 1'b0; out_ready = 1'b1; gap_pct = 0;
    a = 4'($urandom); b = 4'($urandom);
    src_q[1].push_back({1'b0, a});
    src_q[1].push_back({1'b1, b});
    cycle();
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== {2'd1, a}) begin
      n_fail++;
      $display("FAIL bp_first: ov=%b od=%h want 1 %h", out_valid, out_data, {2'd1, a});
    end
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== {2'd1, a} || req_ready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: ov=%b od=%h ready1=%b want 1 %h 0",
                 k, out_valid, out_data, req_ready[1], {2'd1, a});
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    n_checks++;
    if (out_log.size() != 2) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats want 2", out_log.size());
    end else begin
      n_checks++;
      if (out_log[0] !== {1'b0, 2'd1, a} || out_log[1] !== {1'b1, 2'd1, b}) begin
        n_fail++;
        $display("FAIL bp_order: got %h %h want %h %h", out_log[0], out_log[1], {1'b0, 2'd1, a}, {1'b1, 2'd1, b});
      end
    end
  endtask

  task automatic test_hold_grant();
    logic [6:0] exp_log[$];
    logic [3:0] d;
    bit         done;
    clear_sources();
    rand_ready = 1'b0; out_ready = 1'b1; gap_pct = 50;
    for (int k = 0; k < 3; k++) begin
      d = 4'($urandom);
      src_q[3].push_back({k == 2, d});
      exp_log.push_back({k == 2, 2'd3, d});
    end
    cycle();
    n_checks++;
    if (busy !== 1'b1 || grant_id !== 2'd3) begin
      n_fail++;
      $display("FAIL hold_first: busy=%b grant_id=%0d want 1 3", busy, grant_id);
    end
    for (int k = 0; k < 2; k++) begin
      d = 4'($urandom);
      src_q[0].push_back({k == 1, d});
      exp_log.push_back({k == 1, 2'd0, d});
    end
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle();
      if (busy) begin
        n_checks++;
        if (grant_id !== 2'd3 || req_ready[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_keep[%0d]: grant_id=%0d ready0=%b want 3 0", k, grant_id, req_ready[0]);
        end
      end else begin
        done = 1'b1;
      end
    end
    n_checks++;
    if (!done || src_q[3].size() != 0) begin
      n_fail++;
      $display("FAIL hold_timeout: released=%b req3 beats left=%0d want 1 0", done, src_q[3].size());
    end
    cycle();
    n_checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL hold_wrap: busy=%b grant_id=%0d want 1 0", busy, grant_id);
    end
    for (int k = 0; k < 40 && out_log.size() < 5; k++) cycle();
    gap_pct = 0;
    n_checks++;
    if (out_log.size() != 5) begin
      n_fail++;
      $display("FAIL hold_count: got %0d beats want 5", out_log.size());
    end else begin
      foreach (exp_log[j]) begin
        n_checks++;
        if (out_log[j] !== exp_log[j]) begin
          n_fail++;
          $display("FAIL hold_beat[%0d]: got %h want %h", j, out_log[j], exp_log[j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_sources();
    rand_ready = 1'b0; out_ready = 1'b1; gap_pct = 0;
    for (int k = 0; k < 4; k++) src_q[1].push_back({k == 3, 4'(k + 5)});
    cycle();
    cycle();
    cycle();
    rstp = 1'b1;
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || out_data !== 6'h0) begin
      n_fail++;
      $display("FAIL rst_mid: ov=%b busy=%b gid=%0d od=%h want 0 0 0 00", out_valid, busy, grant_id, out_data);
    end
    rstp = 1'b0;
    clear_sources();
    src_q[0].push_back(5'h1a);
    src_q[1].push_back(5'h1b);
    cycle();
    n_checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_prio: busy=%b grant_id=%0d want 1 0", busy, grant_id);
    end
    for (int k = 0; k < 10 && out_log.size() < 2; k++) cycle();
    n_checks++;
    if (out_log.size() != 2 || out_log[0] !== 7'h4a || out_log[1] !== 7'h5b) begin
      n_fail++;
      $display("FAIL rst_order: got %0d beats first=%h want 2 beats 4a 5b", out_log.size(),
               (out_log.size() > 0) ? out_log[0] : 7'h0);
    end
  endtask

  task automatic test_random();
    logic [6:0] exp_log[$];
    logic [4:0] mq[4][$];
    logic [4:0] bt;
    int         ptr, pick, len, sz;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      exp_log.delete();
      gap_pct = 30; stall_pct = 30; rand_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        for (int p = $urandom_range(0, 4); p > 0; p--) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) src_q[i].push_back({k == len - 1, 4'($urandom)});
        end
        mq[i] = src_q[i];
      end
      // Packet-level round robin over requesters that still have packets queued.
      ptr = 0;
      while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0) begin
        pick = -1;
        for (int k = 0; k < 4; k++) begin
          if (pick < 0 && mq[(ptr + k) % 4].size() > 0) pick = (ptr + k) % 4;
        end
        do begin
          bt = mq[pick].pop_front();
          exp_log.push_back({bt[4], 2'(pick), bt[3:0]});
        end while (!bt[4]);
        ptr = (pick + 1) % 4;
      end
      for (int k = 0; k < 3000 && out_log.size() < exp_log.size(); k++) cycle();
      rand_ready = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      sz = out_log.size();
      n_checks++;
      if (sz != exp_log.size()) begin
        n_fail++;
        $display("FAIL rand_count[%0d]: got %0d beats want %0d", r, sz, exp_log.size());
      end else begin
        foreach (exp_log[j]) begin
          n_checks++;
          if (out_log[j] !== exp_log[j]) begin
            n_fail++;
            $display("FAIL rand_beat[%0d][%0d]: got %h want %h", r, j, out_log[j], exp_log[j]);
          end
        end
      end
    end
    gap_pct = 0; stall_pct = 0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_hold_grant();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
